button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter N, default 4: number of push-button channels, legal range 1..8.
REQ-002 SHALL have parameter DB_CYCLES, default 281250 (about 10 ms at 28.125 MHz): the number of consecutive cycles a new input level must persist before it is accepted; minimum 2.
REQ-003 SHALL have parameter LONG_CYCLES, default 28125000 (about 1 s): the hold time that triggers a long-press; minimum 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock. All logic is clocked on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port btn_n, input, N bits: raw button inputs, asynchronous and active-low (0 = pressed).
REQ-007 SHALL have port level, output, N bits: debounced button state, 1 = pressed.
REQ-008 SHALL have port press, output, N bits: one-cycle pulse on each accepted press.
REQ-009 SHALL have port release, output, N bits: one-cycle pulse on each accepted release.
REQ-010 SHALL have port long_press, output, N bits: one-cycle pulse when a press has been held for LONG_CYCLES.
REQ-011 SHALL have port any_pressed, output, 1 bit: OR of all bits of level.

Function
REQ-012 SHALL pass each btn_n bit through a 2-flop synchronizer; the second stage is the "synced sample". Both stages reset to 1 (released).
REQ-013 SHALL give each channel its own debounce counter. The counter increments each cycle while the inverted synced sample differs from level, and clears to 0 on any cycle where they match.
REQ-014 SHALL flip a channel's level bit on the edge where the counter equals DB_CYCLES-1 and the mismatch is still present; the counter clears on the same edge.
REQ-015 SHALL accept a new level only after it is held continuously. Counting the edge that first captures the new btn_n value as edge 1, level updates on edge DB_CYCLES+2.
REQ-016 SHALL ignore glitches: a mismatch lasting fewer than DB_CYCLES synced cycles leaves level unchanged, and no pulses are generated.
REQ-017 SHALL register press and release on the same edge that level changes: press for a 0 to 1 change, release for a 1 to 0 change. Each pulse is exactly 1 cycle, and press and release are never both high on one channel.
REQ-018 SHALL process channels independently: simultaneous transitions on several channels each yield their own pulses in the same cycle.
REQ-019 SHALL register any_pressed in the same cycle as level.
REQ-020 SHALL keep the debounce counters within their range; a counter never wraps.

Reset
REQ-021 SHALL, on any clk edge with rst=1, set level, press, release, long_press and any_pressed to 0, clear all counters, and set both synchronizer stages to 1.
REQ-022 SHALL apply reset mid-operation, including while a channel is held or a debounce count is in progress: no release or long_press pulse is emitted. After rst is deasserted, a still-held button is re-debounced and produces a fresh press.

Configuration
REQ-023 SHALL compile in the long-press feature only when macro BUTTON_DEBOUNCE_LONG_PRESS_EN is defined.
REQ-024 SHALL behave as follows with BUTTON_DEBOUNCE_LONG_PRESS_EN defined:
- each channel has a hold counter that clears when level is 0;
- the hold counter increments while level is 1 and saturates at LONG_CYCLES;
- long_press pulses for 1 cycle on the edge where the counter reaches LONG_CYCLES, which is exactly LONG_CYCLES cycles after the press pulse;
- at most one long_press pulse occurs per press;
- a release before that point produces no long_press.
REQ-025 SHALL, without BUTTON_DEBOUNCE_LONG_PRESS_EN, tie long_press to constant 0 and omit the hold counters; all other behaviour is unchanged.

Verification
REQ-026 SHALL cover a clean press (N=4, DB_CYCLES=4): btn_n[0] goes from 1 to 0 and is held -> level[0]=1 and press[0]=1 for 1 cycle on edge 6, any_pressed=1 from then on, release=0.
REQ-027 SHALL cover a glitch (DB_CYCLES=4): btn_n[1] is low for 3 cycles and then high -> level, press and release stay 0 throughout.
REQ-028 SHALL cover bounce: btn_n[2] toggles every 2 cycles for 20 cycles and then settles at 0 -> exactly one press[2] pulse, on edge 6 after settling; a later settle at 1 -> exactly one release[2] pulse.
REQ-029 SHALL cover simultaneous events: btn_n changes from 4'b1111 to 4'b0101 in one cycle -> press=4'b1010 for 1 cycle, level=4'b1010.
REQ-030 SHALL cover long press (macro defined, LONG_CYCLES=10): hold btn_n[3] low -> long_press[3] pulses once, 10 cycles after press[3], with no further pulse while held. With the macro undefined -> long_press stays 0.
REQ-031 SHALL cover reset while held: with level=4'b0001, assert rst for 1 cycle -> level=0, no release pulse; btn_n[0] still low -> a new press[0] on edge 6 after rst is deasserted.

Source files
------------

// File: rtl/button_debounce.sv
// N-channel push-button debouncer with press/release pulses and optional long-press detection.
// Define BUTTON_DEBOUNCE_LONG_PRESS_EN to build the per-channel hold counters and long_press output.
module button_debounce #(
    parameter int N           = 4,
    parameter int DB_CYCLES   = 281250,
    parameter int LONG_CYCLES = 28125000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn_n,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    // "release" is a reserved word, hence the suffix
    output logic [N-1:0] release_o,
    output logic [N-1:0] long_press,
    output logic         any_pressed
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic [N-1:0]  sync1_q, sync2_q;
    logic [N-1:0]  level_q, level_d;
    logic [N-1:0]  press_q, press_d;
    logic [N-1:0]  release_q, release_d;
    logic          any_q;
    logic [CW-1:0] dbCnt_q [N];
    logic [CW-1:0] dbCnt_d [N];

    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N; i++) begin
            dbCnt_d[i] = '0;
            if (~sync2_q[i] != level_q[i]) begin
                if (dbCnt_q[i] == DB_LAST) begin
                    level_d[i]   = ~level_q[i];
                    press_d[i]   = ~level_q[i];
                    release_d[i] = level_q[i];
                end else begin
                    dbCnt_d[i] = dbCnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
            for (int i = 0; i < N; i++) dbCnt_q[i] <= '0;
        end else begin
            sync1_q   <= btn_n;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            any_q     <= |level_d;
            for (int i = 0; i < N; i++) dbCnt_q[i] <= dbCnt_d[i];
        end
    end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hold_q [N];
    logic [HW-1:0] hold_d [N];
    logic [N-1:0]  long_q, long_d;

    // Hold counter saturates, so the pulse fires only once per press
    always_comb begin
        long_d = '0;
        for (int i = 0; i < N; i++) begin
            hold_d[i] = hold_q[i];
            if (!level_q[i]) begin
                hold_d[i] = '0;
            end else if (hold_q[i] != HOLD_MAX) begin
                hold_d[i] = hold_q[i] + 1'b1;
                long_d[i] = (hold_q[i] == HOLD_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            long_q <= '0;
            for (int i = 0; i < N; i++) hold_q[i] <= '0;
        end else begin
            long_q <= long_d;
            for (int i = 0; i < N; i++) hold_q[i] <= hold_d[i];
        end
    end

    assign long_press = long_q;
`else
    assign long_press = '0;
`endif

    assign level       = level_q;
    assign press       = press_q;
    assign release_o   = release_q;
    assign any_pressed = any_q;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (N=4, DB_CYCLES=4, LONG_CYCLES=10).
// Long-press expectations follow BUTTON_DEBOUNCE_LONG_PRESS_EN.
module tb_button_debounce;

    typedef struct {
        logic [3:0] btn;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] btn_n;
    logic [3:0] level, press, release_o, long_press;
    logic       any_pressed;

    int   checkCount = 0;
    int   errorCount = 0;
    vec_t vecs[$];

    button_debounce #(.N(4), .DB_CYCLES(4), .LONG_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n), .level(level), .press(press),
        .release_o(release_o), .long_press(long_press), .any_pressed(any_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    task automatic addVec(input logic [3:0] b, input logic [3:0] l, input logic [3:0] p,
                          input logic [3:0] r, input int n);
        vec_t v;
        v.btn = b; v.lvl = l; v.prs = p; v.rel = r;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < vecs.size(); i++) begin
            btn_n = vecs[i].btn;
            tick();
            checkOutput($sformatf("vec%0d level", i), int'(level), int'(vecs[i].lvl));
            checkOutput($sformatf("vec%0d press", i), int'(press), int'(vecs[i].prs));
            checkOutput($sformatf("vec%0d release", i), int'(release_o), int'(vecs[i].rel));
            checkOutput($sformatf("vec%0d any", i), int'(any_pressed), int'(|vecs[i].lvl));
            checkOutput($sformatf("vec%0d long", i), int'(long_press), 0);
        end
    endtask

    initial begin
        int pressCnt, relCnt, longCnt, firstEdge;
        bit found;

        rst   = 1'b1;
        btn_n = 4'b1111;
        tick();
        btn_n = 4'b0000;
        tick();
        checkOutput("reset level", int'(level), 0);
        checkOutput("reset press", int'(press), 0);
        checkOutput("reset any", int'(any_pressed), 0);
        btn_n = 4'b1111;
        rst   = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("idle level", int'(level), 0);

        // clean press / release of ch0, glitch on ch1, simultaneous ch1+ch3
        addVec(4'b1110, 4'b0000, 4'b0000, 4'b0000, 5);
        addVec(4'b1110, 4'b0001, 4'b0001, 4'b0000, 1);
        addVec(4'b1110, 4'b0001, 4'b0000, 4'b0000, 2);
        addVec(4'b1111, 4'b0001, 4'b0000, 4'b0000, 5);
        addVec(4'b1111, 4'b0000, 4'b0000, 4'b0001, 1);
        addVec(4'b1111, 4'b0000, 4'b0000, 4'b0000, 1);
        addVec(4'b1101, 4'b0000, 4'b0000, 4'b0000, 3);
        addVec(4'b1111, 4'b0000, 4'b0000, 4'b0000, 6);
        addVec(4'b0101, 4'b0000, 4'b0000, 4'b0000, 5);
        addVec(4'b0101, 4'b1010, 4'b1010, 4'b0000, 1);
        addVec(4'b0101, 4'b1010, 4'b0000, 4'b0000, 1);
        addVec(4'b1111, 4'b1010, 4'b0000, 4'b0000, 5);
        addVec(4'b1111, 4'b0000, 4'b0000, 4'b1010, 1);
        addVec(4'b1111, 4'b0000, 4'b0000, 4'b0000, 2);
        applyStimulus();

        // bounce on ch2, settling low
        pressCnt = 0; relCnt = 0; firstEdge = 0;
        for (int c = 0; c < 20; c++) begin
            btn_n = ((c % 4) < 2) ? 4'b1011 : 4'b1111;
            tick();
            if (press[2]) pressCnt++;
            if (release_o[2]) relCnt++;
        end
        checkOutput("bounce press during toggling", pressCnt, 0);
        btn_n = 4'b1011;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (press[2]) begin
                pressCnt++;
                if (firstEdge == 0) firstEdge = e;
            end
            if (release_o[2]) relCnt++;
        end
        checkOutput("bounce press count", pressCnt, 1);
        checkOutput("bounce press edge", firstEdge, 6);
        checkOutput("bounce release count", relCnt, 0);
        checkOutput("bounce level", int'(level), 4);

        // bounce on ch2, settling high
        pressCnt = 0; relCnt = 0; firstEdge = 0;
        for (int c = 0; c < 20; c++) begin
            btn_n = ((c % 4) < 2) ? 4'b1111 : 4'b1011;
            tick();
            if (press[2]) pressCnt++;
            if (release_o[2]) relCnt++;
        end
        checkOutput("unbounce release during toggling", relCnt, 0);
        btn_n = 4'b1111;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (press[2]) pressCnt++;
            if (release_o[2]) begin
                relCnt++;
                if (firstEdge == 0) firstEdge = e;
            end
        end
        checkOutput("unbounce release count", relCnt, 1);
        checkOutput("unbounce release edge", firstEdge, 6);
        checkOutput("unbounce press count", pressCnt, 0);
        checkOutput("unbounce level", int'(level), 0);

        // long press on ch3
        btn_n = 4'b0111;
        found = 1'b0;
        for (int e = 1; e <= 20 && !found; e++) begin
            tick();
            if (press[3]) found = 1'b1;
        end
        checkOutput("long press seen", int'(found), 1);
        longCnt = 0; firstEdge = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (long_press[3]) begin
                longCnt++;
                if (firstEdge == 0) firstEdge = e;
            end
        end
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        checkOutput("long pulse count", longCnt, 1);
        checkOutput("long pulse delay", firstEdge, 10);
`else
        checkOutput("long pulse count", longCnt, 0);
`endif
        btn_n = 4'b1111;
        for (int e = 0; e < 8; e++) tick();
        checkOutput("long release level", int'(level), 0);

        // reset while ch0 held
        btn_n = 4'b1110;
        for (int e = 0; e < 6; e++) tick();
        checkOutput("rsthold press", int'(press), 1);
        checkOutput("rsthold level", int'(level), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rsthold level after rst", int'(level), 0);
        checkOutput("rsthold release after rst", int'(release_o), 0);
        checkOutput("rsthold any after rst", int'(any_pressed), 0);
        pressCnt = 0; relCnt = 0; firstEdge = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (press[0]) begin
                pressCnt++;
                if (firstEdge == 0) firstEdge = e;
            end
            if (release_o != 4'b0000 || long_press != 4'b0000) relCnt++;
        end
        checkOutput("rsthold repress count", pressCnt, 1);
        checkOutput("rsthold repress edge", firstEdge, 6);
        checkOutput("rsthold stray pulses", relCnt, 0);
        checkOutput("rsthold final level", int'(level), 1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
